// File: rtl/dice_pkg.sv
// Shared types and face patterns for the dice result keeper.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROLLING,
        BLINK
    } state_t;

    localparam logic [6:0] FACE_1   = 7'h08;
    localparam logic [6:0] FACE_2   = 7'h41;
    localparam logic [6:0] FACE_3   = 7'h49;
    localparam logic [6:0] FACE_4   = 7'h63;
    localparam logic [6:0] FACE_5   = 7'h6B;
    localparam logic [6:0] FACE_6   = 7'h77;
    localparam logic [6:0] FACE_OFF = 7'h00;

    // LED order {TL,TR,ML,C,MR,BL,BR}; illegal values show a dark face.
    function automatic logic [6:0] face_of(input logic [2:0] value);
        logic [6:0] face;
        face = FACE_OFF;
        case (value)
            3'd1:    face = FACE_1;
            3'd2:    face = FACE_2;
            3'd3:    face = FACE_3;
            3'd4:    face = FACE_4;
            3'd5:    face = FACE_5;
            3'd6:    face = FACE_6;
            default: face = FACE_OFF;
        endcase
        return face;
    endfunction

endpackage

// File: rtl/dice_result_keeper_if.sv
// Dice input and score/face output bundle between the dice and the board logic.
interface dice_result_keeper_if #(
    parameter int unsigned TOTAL_W = 8,
    parameter int unsigned CNT_W   = 6
);
    logic               button;
    logic [2:0]         throw;
    logic [2:0]         result;
    logic               result_valid;
    logic [6:0]         face;
    logic [TOTAL_W-1:0] total;
    logic [CNT_W-1:0]   rolls;
    logic               busy;

    modport master (
        output button, throw,
        input  result, result_valid, face, total, rolls, busy
    );

    modport slave (
        input  button, throw,
        output result, result_valid, face, total, rolls, busy
    );
endinterface

// File: rtl/dice_face_decoder.sv
// Combinational dice value to 7-LED face pattern.
module dice_face_decoder
    import dice_pkg::*;
(
    input  logic [2:0] i_value,
    output logic [6:0] o_face_c
);
    assign o_face_c = face_of(i_value);
endmodule

// File: rtl/dice_result_keeper.sv
// Captures the dice value on button release, blinks the face and keeps a
// saturating score and a wrapping roll count.
module dice_result_keeper
    import dice_pkg::*;
#(
    parameter int unsigned BLINK_CYCLES = 8,
    parameter int unsigned TOTAL_W      = 8,
    parameter int unsigned CNT_W        = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    dice_result_keeper_if.slave   bus
);
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam int unsigned SUM_W   = TOTAL_W + 1;

    state_t             r_state;
    logic               r_button_q;
    logic [2:0]         r_result;
    logic               r_result_valid;
    logic [TOTAL_W-1:0] r_total;
    logic [CNT_W-1:0]   r_rolls;
    logic [BLINK_W-1:0] r_cnt;

    logic               w_release;
    logic               w_throw_ok;
    logic [SUM_W-1:0]   w_sum;
    logic [TOTAL_W-1:0] w_total_next;
    logic [6:0]         w_live_face;
    logic [6:0]         w_result_face;
    logic [6:0]         w_face;

    assign w_release    = r_button_q & ~bus.button;
    assign w_throw_ok   = (bus.throw != 3'd0) && (bus.throw != 3'd7);
    assign w_sum        = {1'b0, r_total} + SUM_W'(bus.throw);
    assign w_total_next = w_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : w_sum[TOTAL_W-1:0];

    dice_face_decoder u_live_face (
        .i_value  (bus.throw),
        .o_face_c (w_live_face)
    );

    dice_face_decoder u_result_face (
        .i_value  (r_result),
        .o_face_c (w_result_face)
    );

    // Roll FSM with capture, scoring and blink countdown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_button_q     <= 1'b0;
            r_result       <= 3'd0;
            r_result_valid <= 1'b0;
            r_total        <= '0;
            r_rolls        <= '0;
            r_cnt          <= '0;
        end else begin
            r_button_q     <= bus.button;
            r_result_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.button) r_state <= ROLLING;
                end
                ROLLING: begin
                    if (w_release) begin
                        if (w_throw_ok) begin
                            r_result       <= bus.throw;
                            r_result_valid <= 1'b1;
                            r_total        <= w_total_next;
                            r_rolls        <= r_rolls + CNT_W'(1);
                            r_cnt          <= BLINK_W'(BLINK_CYCLES - 1);
                            r_state        <= BLINK;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                BLINK: begin
                    // A new press cuts the blink short.
                    if (bus.button)        r_state <= ROLLING;
                    else if (r_cnt == '0)  r_state <= IDLE;
                    else                   r_cnt   <= r_cnt - BLINK_W'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_face = FACE_OFF;
        case (r_state)
            ROLLING: w_face = w_live_face;
            BLINK:   w_face = r_cnt[0] ? FACE_OFF : w_result_face;
            default: w_face = w_result_face;
        endcase
    end

    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
    assign bus.face         = w_face;
    assign bus.total        = r_total;
    assign bus.rolls        = r_rolls;
    assign bus.busy         = (r_state != IDLE);

endmodule
